raizing_clk_sequencer: RTL and testbench



---
 rtl/raizing_clk_pkg.sv | 18 +
 rtl/raizing_frac_cen.sv | 44 ++++
 rtl/raizing_clk_sequencer.sv | 109 ++++++++++
 tb/tb_raizing_clk_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raizing_clk_pkg.sv
// Shared types and default ratios for the PLL-consumer clock sequencer.
package raizing_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int unsigned SYS_CLK_KHZ = 94500;

  // 94.5 MHz * 32/189 = 16 MHz (68000), 94.5 MHz * 8/189 = 4 MHz (Z80)
  localparam int unsigned NUM_16M = 32;
  localparam int unsigned DEN_16M = 189;
  localparam int unsigned NUM_4M  = 8;
  localparam int unsigned DEN_4M  = 189;

endpackage

// File: rtl/raizing_frac_cen.sv
// One fractional clock-enable channel: emits NUM pulses per DEN cycles while en=1.
module raizing_frac_cen #(
  parameter int unsigned W   = 16,
  parameter int unsigned NUM = 32,
  parameter int unsigned DEN = 189
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic cen
);

  localparam int unsigned AW = W + 1;

  if (NUM > DEN) begin : g_bad_num
    $error("raizing_frac_cen: NUM must not exceed DEN");
  end
  if (64'(DEN) >= (64'(1) << W)) begin : g_bad_den
    $error("raizing_frac_cen: DEN must be below 2**W");
  end

  logic [AW-1:0] acc;
  logic [AW-1:0] nxt_c;

  // One spare bit keeps acc + NUM from wrapping since acc < DEN < 2**W.
  assign nxt_c = acc + AW'(NUM);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (hold) begin
      cen <= 1'b0;
    end else if (nxt_c >= AW'(DEN)) begin
      acc <= nxt_c - AW'(DEN);
      cen <= 1'b1;
    end else begin
      acc <= nxt_c;
      cen <= 1'b0;
    end
  end

endmodule

// File: rtl/raizing_clk_sequencer.sv
// PLL lock sequencer: holds rst_out until lock settles, then runs two fractional enables.
// Optional RAIZING_CLK_PAUSE_EN adds a pause input that freezes both channels in RUN.
module raizing_clk_sequencer
  import raizing_clk_pkg::*;
#(
  parameter int unsigned W             = 16,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned NUM0          = NUM_16M,
  parameter int unsigned DEN0          = DEN_16M,
  parameter int unsigned NUM1          = NUM_4M,
  parameter int unsigned DEN1          = DEN_4M
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
`ifdef RAIZING_CLK_PAUSE_EN
  input  logic pause,
`endif
  output logic rst_out,
  output logic cen0,
  output logic cen1,
  output logic running
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("raizing_clk_sequencer: SETTLE_CYCLES must be at least 1");
  end

  logic          sync1;
  logic          lk_s;
  state_e        state;
  logic [CW-1:0] cnt;
  logic          en_c;
  logic          hold_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      lk_s    <= 1'b0;
      state   <= WAIT_LOCK;
      cnt     <= '0;
      rst_out <= 1'b1;
      running <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
      case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lk_s) state <= SETTLE;
        end
        SETTLE: begin
          if (!lk_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state   <= RUN;
            cnt     <= '0;
            rst_out <= 1'b0;
            running <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!lk_s) begin
            state   <= WAIT_LOCK;
            rst_out <= 1'b1;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          cnt     <= '0;
          rst_out <= 1'b1;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Channels advance only on edges that keep the FSM in RUN, so a lock loss kills enables at once.
  assign en_c = (state == RUN) && lk_s;

`ifdef RAIZING_CLK_PAUSE_EN
  assign hold_c = pause;
`else
  assign hold_c = 1'b0;
`endif

  raizing_frac_cen #(.W(W), .NUM(NUM0), .DEN(DEN0)) u_ch0 (
    .clk  (clk),
    .rst  (rst),
    .en   (en_c),
    .hold (hold_c),
    .cen  (cen0)
  );

  raizing_frac_cen #(.W(W), .NUM(NUM1), .DEN(DEN1)) u_ch1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en_c),
    .hold (hold_c),
    .cen  (cen1)
  );

endmodule

// File: tb/tb_raizing_clk_sequencer.sv
// Bench for raizing_clk_sequencer: default-ratio DUT plus an override DUT (NUM0=DEN0=5, NUM1=0).
module tb_raizing_clk_sequencer;

  localparam int S        = 64;
  localparam int RATE_CYC = 18900;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pll_locked;
`ifdef RAIZING_CLK_PAUSE_EN
  logic pause;
`endif
  logic rst_out, cen0, cen1, running;
  logic o_rst_out, o_cen0, o_cen1, o_running;
  logic [7:0] obs;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  assign obs = {rst_out, running, cen0, cen1, o_rst_out, o_running, o_cen0, o_cen1};

  raizing_clk_sequencer #(.W(16), .SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
`ifdef RAIZING_CLK_PAUSE_EN
    .pause      (pause),
`endif
    .rst_out    (rst_out),
    .cen0       (cen0),
    .cen1       (cen1),
    .running    (running)
  );

  raizing_clk_sequencer #(.W(16), .SETTLE_CYCLES(S), .NUM0(5), .DEN0(5), .NUM1(0), .DEN1(189)) dut_ovr (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
`ifdef RAIZING_CLK_PAUSE_EN
    .pause      (pause),
`endif
    .rst_out    (o_rst_out),
    .cen0       (o_cen0),
    .cen1       (o_cen1),
    .running    (o_running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse at the k-th accumulating cycle iff floor(k*num/den) steps up.
  function automatic logic exp_cen(input int k, input int num, input int den);
    return ((k * num) / den) != (((k - 1) * num) / den);
  endfunction

  // Expected {rst_out,running,cen0,cen1} for both DUTs; acc=1 means this edge accumulated (k-th time).
  function automatic logic [7:0] exp_vec(input bit run, input bit acc, input int k);
    logic c0, c1, o0, o1;
    if (!run) return 8'b1000_1000;
    c0 = acc && exp_cen(k, 32, 189);
    c1 = acc && exp_cen(k, 8, 189);
    o0 = acc && exp_cen(k, 5, 5);
    o1 = acc && exp_cen(k, 0, 189);
    return {1'b0, 1'b1, c0, c1, 1'b0, 1'b1, o0, o1};
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    rst = 1'b1;
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (obs !== 8'b1000_1000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, 8'b1000_1000);
      end
    end
    rst = 1'b0;
    // lk_s rises at edge 2, RUN entered S+1 edges later
    for (int e_i = 1; e_i <= S + 3; e_i++) begin
      tick();
      e = (e_i == S + 3) ? exp_vec(1, 0, 0) : exp_vec(0, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL reset_release edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    n = 0;
  endtask

  task automatic test_rate();
    logic [7:0] e;
    int p0 = 0, p1 = 0, op0 = 0, op1 = 0, first0 = 0;
    for (int i = 0; i < RATE_CYC; i++) begin
      tick();
      n++;
      e = exp_vec(1, 1, n);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL rate_cycle k=%0d got=%b want=%b", n, obs, e);
      end
      if (cen0) p0++;
      if (cen1) p1++;
      if (o_cen0) op0++;
      if (o_cen1) op1++;
      if (cen0 && first0 == 0) first0 = n;
    end
    total++;
    if (first0 !== 6) begin
      bad++;
      $display("FAIL first_cen0 got=%0d want=6", first0);
    end
    total++;
    if (p0 !== RATE_CYC * 32 / 189 || p1 !== RATE_CYC * 8 / 189) begin
      bad++;
      $display("FAIL rate_count got=%0d/%0d want=%0d/%0d", p0, p1, RATE_CYC * 32 / 189, RATE_CYC * 8 / 189);
    end
    total++;
    if (op0 !== RATE_CYC || op1 !== 0) begin
      bad++;
      $display("FAIL override_count got=%0d/%0d want=%0d/0", op0, op1, RATE_CYC);
    end
  endtask

  task automatic test_run_drop();
    logic [7:0] e;
    int k, first0;
    k = $urandom_range(5, 300);
    for (int i = 0; i < k; i++) begin
      tick();
      n++;
      e = exp_vec(1, 1, n);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_pre k=%0d got=%b want=%b", n, obs, e);
      end
    end
    pll_locked = 1'b0;
    // lk_s still high for two more edges, RUN exits on the third
    for (int e_i = 1; e_i <= 10; e_i++) begin
      tick();
      if (e_i <= 2) begin
        n++;
        e = exp_vec(1, 1, n);
      end else begin
        e = exp_vec(0, 0, 0);
      end
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_low edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    pll_locked = 1'b1;
    for (int e_i = 1; e_i <= S + 3; e_i++) begin
      tick();
      e = (e_i == S + 3) ? exp_vec(1, 0, 0) : exp_vec(0, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_relock edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    n = 0;
    first0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n++;
      e = exp_vec(1, 1, n);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL drop_restart k=%0d got=%b want=%b", n, obs, e);
      end
      if (cen0 && first0 == 0) first0 = n;
    end
    total++;
    if (first0 !== 6) begin
      bad++;
      $display("FAIL drop_first_cen0 got=%0d want=6", first0);
    end
  endtask

  task automatic test_settle_glitch();
    logic [7:0] e;
    int c;
    pll_locked = 1'b0;
    for (int e_i = 1; e_i <= 12; e_i++) begin
      tick();
      if (e_i <= 2) begin
        n++;
        e = exp_vec(1, 1, n);
      end else begin
        e = exp_vec(0, 0, 0);
      end
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch_exit edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    pll_locked = 1'b1;
    c = $urandom_range(4, S - 8);
    // SETTLE entered at edge 3; counter reaches c at edge 3+c
    for (int e_i = 1; e_i <= 3 + c + 10; e_i++) begin
      if (e_i == 3 + c + 1) pll_locked = 1'b0;
      tick();
      e = exp_vec(0, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch_settle edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    pll_locked = 1'b1;
    for (int e_i = 1; e_i <= S + 3; e_i++) begin
      tick();
      e = (e_i == S + 3) ? exp_vec(1, 0, 0) : exp_vec(0, 0, 0);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL glitch_relock edge=%0d got=%b want=%b", e_i, obs, e);
      end
    end
    n = 0;
  endtask

`ifdef RAIZING_CLK_PAUSE_EN
  task automatic test_pause();
    logic [7:0] e;
    int ps, u, p0, p1;
    bit done;
    ps = $urandom_range(10, RATE_CYC - 200);
    u = 0; p0 = 0; p1 = 0; done = 1'b0;
    while (u < RATE_CYC) begin
      if (u == ps && !done) begin
        pause = 1'b1;
        for (int i = 0; i < 100; i++) begin
          tick();
          e = exp_vec(1, 0, n);
          total++;
          if (obs !== e) begin
            bad++;
            $display("FAIL pause_hold i=%0d got=%b want=%b", i, obs, e);
          end
        end
        pause = 1'b0;
        done = 1'b1;
      end else begin
        tick();
        n++;
        u++;
        e = exp_vec(1, 1, n);
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL pause_run k=%0d got=%b want=%b", n, obs, e);
        end
        if (cen0) p0++;
        if (cen1) p1++;
      end
    end
    total++;
    if (p0 !== RATE_CYC * 32 / 189 || p1 !== RATE_CYC * 8 / 189) begin
      bad++;
      $display("FAIL pause_count got=%0d/%0d want=%0d/%0d", p0, p1, RATE_CYC * 32 / 189, RATE_CYC * 8 / 189);
    end
  endtask
`endif

  initial begin
`ifdef RAIZING_CLK_PAUSE_EN
    pause = 1'b0;
`endif
    test_reset();
    test_rate();
    test_run_drop();
    test_settle_glitch();
`ifdef RAIZING_CLK_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
